// File: rtl/rob_if.sv
// Reorder buffer port bundle: flush, dispatch allocation, EX writeback, retire
// and forwarding lookup. The ROB itself sits on the slave side.
interface rob_if #(
  parameter int SLOT_W = 4
);
  logic              flush;
  logic              alloc_req;
  logic [4:0]        alloc_dest_reg;
  logic              alloc_dest_valid;
  logic              alloc_ready;
  logic [SLOT_W-1:0] alloc_slot;
  logic              wb_valid;
  logic [SLOT_W-1:0] wb_slot;
  logic [31:0]       wb_result_hi;
  logic [31:0]       wb_result_lo;
  logic              commit_valid;
  logic [4:0]        commit_dest_reg;
  logic              commit_dest_valid;
  logic [31:0]       commit_result_hi;
  logic [31:0]       commit_result_lo;
  logic [SLOT_W-1:0] rd_a_slot;
  logic [SLOT_W-1:0] rd_b_slot;
  logic              rd_a_done;
  logic              rd_b_done;
  logic [31:0]       rd_a_data;
  logic [31:0]       rd_b_data;

  modport master (
    output flush, alloc_req, alloc_dest_reg, alloc_dest_valid,
           wb_valid, wb_slot, wb_result_hi, wb_result_lo, rd_a_slot, rd_b_slot,
    input  alloc_ready, alloc_slot, commit_valid, commit_dest_reg, commit_dest_valid,
           commit_result_hi, commit_result_lo, rd_a_done, rd_b_done, rd_a_data, rd_b_data
  );

  modport slave (
    input  flush, alloc_req, alloc_dest_reg, alloc_dest_valid,
           wb_valid, wb_slot, wb_result_hi, wb_result_lo, rd_a_slot, rd_b_slot,
    output alloc_ready, alloc_slot, commit_valid, commit_dest_reg, commit_dest_valid,
           commit_result_hi, commit_result_lo, rd_a_done, rd_b_done, rd_a_data, rd_b_data
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order writeback, in-order retire (one per cycle).
// Define ROB_FWD_EN to enable the rd_a/rd_b forwarding lookup with same-cycle writeback bypass.
module rob #(
  parameter  int DEPTH  = 16,
  localparam int SLOT_W = $clog2(DEPTH)
) (
  input logic  clock,
  input logic  reset_n,
  rob_if.slave bus
);
  localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W+1)'(DEPTH);

  logic [SLOT_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [SLOT_W:0]   count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]  dest_valid_q, dest_valid_d;
  logic [4:0]        dest_reg_q [DEPTH];
  logic [4:0]        dest_reg_d [DEPTH];
  logic [31:0]       hi_q [DEPTH];
  logic [31:0]       hi_d [DEPTH];
  logic [31:0]       lo_q [DEPTH];
  logic [31:0]       lo_d [DEPTH];

  logic              commit_valid_q, commit_valid_d;
  logic [4:0]        commit_dest_reg_q, commit_dest_reg_d;
  logic              commit_dest_valid_q, commit_dest_valid_d;
  logic [31:0]       commit_hi_q, commit_hi_d;
  logic [31:0]       commit_lo_q, commit_lo_d;

  logic alloc_ready;
  logic alloc_fire;
  logic wb_hit;
  logic commit_fire;

  // Full gating uses the current count, so a full ROB refuses alloc even while retiring.
  assign alloc_ready = (count_q != FULL_CNT);
  assign alloc_fire  = bus.alloc_req & alloc_ready & ~bus.flush;
  assign wb_hit      = bus.wb_valid & valid_q[bus.wb_slot];
  assign commit_fire = (count_q != '0) & valid_q[head_q] & done_q[head_q];

  // Next-state for pointers, per-entry flags/payload and the retire registers.
  always_comb begin
    valid_d             = valid_q;
    done_d              = done_q;
    dest_valid_d        = dest_valid_q;
    dest_reg_d          = dest_reg_q;
    hi_d                = hi_q;
    lo_d                = lo_q;
    head_d              = head_q;
    tail_d              = tail_q;
    count_d             = count_q;
    commit_valid_d      = 1'b0;
    commit_dest_reg_d   = 5'd0;
    commit_dest_valid_d = 1'b0;
    commit_hi_d         = 32'd0;
    commit_lo_d         = 32'd0;
    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_fire && (tail_q == SLOT_W'(i))) begin
          valid_d[i]      = 1'b1;
          done_d[i]       = 1'b0;
          dest_reg_d[i]   = bus.alloc_dest_reg;
          dest_valid_d[i] = bus.alloc_dest_valid;
        end else begin
          if (wb_hit && (bus.wb_slot == SLOT_W'(i))) begin
            done_d[i] = 1'b1;
            hi_d[i]   = bus.wb_result_hi;
            lo_d[i]   = bus.wb_result_lo;
          end else begin
            done_d[i] = done_q[i];
          end
          if (commit_fire && (head_q == SLOT_W'(i))) begin
            valid_d[i] = 1'b0;
          end else begin
            valid_d[i] = valid_q[i];
          end
        end
      end
      if (commit_fire) begin
        commit_valid_d      = 1'b1;
        commit_dest_reg_d   = dest_reg_q[head_q];
        commit_dest_valid_d = dest_valid_q[head_q];
        commit_hi_d         = hi_q[head_q];
        commit_lo_d         = lo_q[head_q];
        head_d              = head_q + SLOT_W'(1);
      end else begin
        head_d = head_q;
      end
      if (alloc_fire) begin
        tail_d = tail_q + SLOT_W'(1);
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + {{SLOT_W{1'b0}}, alloc_fire} - {{SLOT_W{1'b0}}, commit_fire};
    end
  end

  // Control state and retire registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q              <= '0;
      tail_q              <= '0;
      count_q             <= '0;
      valid_q             <= '0;
      done_q              <= '0;
      commit_valid_q      <= 1'b0;
      commit_dest_reg_q   <= 5'd0;
      commit_dest_valid_q <= 1'b0;
      commit_hi_q         <= 32'd0;
      commit_lo_q         <= 32'd0;
    end else begin
      head_q              <= head_d;
      tail_q              <= tail_d;
      count_q             <= count_d;
      valid_q             <= valid_d;
      done_q              <= done_d;
      commit_valid_q      <= commit_valid_d;
      commit_dest_reg_q   <= commit_dest_reg_d;
      commit_dest_valid_q <= commit_dest_valid_d;
      commit_hi_q         <= commit_hi_d;
      commit_lo_q         <= commit_lo_d;
    end
  end

  // Payload storage; only ever observed through valid/done, so it needs no reset.
  always_ff @(posedge clock) begin
    dest_reg_q   <= dest_reg_d;
    dest_valid_q <= dest_valid_d;
    hi_q         <= hi_d;
    lo_q         <= lo_d;
  end

  assign bus.alloc_slot        = tail_q;
  assign bus.alloc_ready       = alloc_ready;
  assign bus.commit_valid      = commit_valid_q;
  assign bus.commit_dest_reg   = commit_dest_reg_q;
  assign bus.commit_dest_valid = commit_dest_valid_q;
  assign bus.commit_result_hi  = commit_hi_q;
  assign bus.commit_result_lo  = commit_lo_q;

`ifdef ROB_FWD_EN
  logic [32:0] rd_a_lkp, rd_b_lkp;

  // Returns {done, data}; data is held at zero while the slot has no result.
  function automatic logic [32:0] fwd_pick(input logic ent_valid, input logic ent_done,
                                           input logic byp, input logic [31:0] byp_data,
                                           input logic [31:0] ent_data);
    logic [32:0] r;
    if (ent_valid && byp) begin
      r = {1'b1, byp_data};
    end else if (ent_valid && ent_done) begin
      r = {1'b1, ent_data};
    end else begin
      r = 33'd0;
    end
    return r;
  endfunction

  // Forwarding lookups with same-cycle writeback bypass.
  always_comb begin
    rd_a_lkp = fwd_pick(valid_q[bus.rd_a_slot], done_q[bus.rd_a_slot],
                        bus.wb_valid && (bus.wb_slot == bus.rd_a_slot),
                        bus.wb_result_lo, lo_q[bus.rd_a_slot]);
    rd_b_lkp = fwd_pick(valid_q[bus.rd_b_slot], done_q[bus.rd_b_slot],
                        bus.wb_valid && (bus.wb_slot == bus.rd_b_slot),
                        bus.wb_result_lo, lo_q[bus.rd_b_slot]);
  end

  assign bus.rd_a_done = rd_a_lkp[32];
  assign bus.rd_a_data = rd_a_lkp[31:0];
  assign bus.rd_b_done = rd_b_lkp[32];
  assign bus.rd_b_data = rd_b_lkp[31:0];
`else
  assign bus.rd_a_done = 1'b0;
  assign bus.rd_a_data = 32'd0;
  assign bus.rd_b_done = 1'b0;
  assign bus.rd_b_data = 32'd0;
`endif

`ifndef SYNTHESIS
  rob_chk #(.SLOT_W(SLOT_W)) u_chk (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (bus.flush),
    .wb_valid   (bus.wb_valid),
    .wb_slot    (bus.wb_slot),
    .slot_valid (valid_q[bus.wb_slot])
  );
`endif
endmodule

`ifndef SYNTHESIS
module rob_chk #(
  parameter int SLOT_W = 4
) (
  input logic              clock,
  input logic              reset_n,
  input logic              flush,
  input logic              wb_valid,
  input logic [SLOT_W-1:0] wb_slot,
  input logic              slot_valid
);
  // Flags writebacks that target a slot holding no in-flight instruction.
  always @(posedge clock) begin
    if (reset_n && !flush && wb_valid) begin
      assert (slot_valid) else $warning("rob: writeback to unallocated slot %0d ignored", wb_slot);
    end
  end
endmodule
`endif

// File: tb/tb_rob.sv
// Directed bench for rob: fill/full, in-order retire, full-wrap, flush, forwarding and mid-stream reset.
module tb_rob;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

`ifdef ROB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  rob_if #(.SLOT_W(4)) bus ();

  rob #(.DEPTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.flush            = 1'b0;
    bus.alloc_req        = 1'b0;
    bus.alloc_dest_reg   = 5'd0;
    bus.alloc_dest_valid = 1'b0;
    bus.wb_valid         = 1'b0;
    bus.wb_slot          = 4'd0;
    bus.wb_result_hi     = 32'd0;
    bus.wb_result_lo     = 32'd0;
    bus.rd_a_slot        = 4'd0;
    bus.rd_b_slot        = 4'd0;
  endtask

  task automatic alloc(input logic [4:0] d, input logic v);
    bus.alloc_req        = 1'b1;
    bus.alloc_dest_reg   = d;
    bus.alloc_dest_valid = v;
  endtask

  task automatic wb(input logic [3:0] s, input logic [31:0] hi, input logic [31:0] lo);
    bus.wb_valid     = 1'b1;
    bus.wb_slot      = s;
    bus.wb_result_hi = hi;
    bus.wb_result_lo = lo;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    settle();
    chk("rst_ready",   64'(bus.alloc_ready),      64'd1);
    chk("rst_slot",    64'(bus.alloc_slot),       64'd0);
    chk("rst_cv",      64'(bus.commit_valid),     64'd0);
    chk("rst_dest",    64'(bus.commit_dest_reg),  64'd0);
    chk("rst_lo",      64'(bus.commit_result_lo), 64'd0);
    chk("rst_rd_done", 64'(bus.rd_a_done),        64'd0);

    // Fill all 16 slots, then the 17th request must stall.
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i), 1'b1);
      settle();
      chk("fill_ready", 64'(bus.alloc_ready), 64'd1);
      chk("fill_slot",  64'(bus.alloc_slot),  64'(i));
      tick();
    end
    settle();
    chk("full_ready", 64'(bus.alloc_ready), 64'd0);
    chk("full_slot",  64'(bus.alloc_slot),  64'd0);
    tick();
    chk("nogrant_ready", 64'(bus.alloc_ready),  64'd0);
    chk("nogrant_cv",    64'(bus.commit_valid), 64'd0);

    // Full ROB: head completes while alloc_req is held.
    alloc(5'd20, 1'b0);
    wb(4'd0, 32'h1, 32'hA0);
    settle();
    chk("wrap_ready_t0", 64'(bus.alloc_ready), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("wrap_ready_t1", 64'(bus.alloc_ready),  64'd0);
    chk("wrap_cv_t1",    64'(bus.commit_valid), 64'd0);
    tick();
    settle();
    chk("wrap_cv",     64'(bus.commit_valid),      64'd1);
    chk("wrap_dest",   64'(bus.commit_dest_reg),   64'd0);
    chk("wrap_dv",     64'(bus.commit_dest_valid), 64'd1);
    chk("wrap_hi",     64'(bus.commit_result_hi),  64'h1);
    chk("wrap_lo",     64'(bus.commit_result_lo),  64'hA0);
    chk("wrap_ready",  64'(bus.alloc_ready),       64'd1);
    chk("wrap_slot",   64'(bus.alloc_slot),        64'd0);
    tick();
    bus.alloc_req = 1'b0;
    settle();
    chk("refull_ready", 64'(bus.alloc_ready),  64'd0);
    chk("refull_cv",    64'(bus.commit_valid), 64'd0);
    chk("refull_slot",  64'(bus.alloc_slot),   64'd1);

    // Clear the full ROB with a flush.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    settle();
    chk("clr_cv",    64'(bus.commit_valid), 64'd0);
    chk("clr_ready", 64'(bus.alloc_ready),  64'd1);
    chk("clr_slot",  64'(bus.alloc_slot),   64'd0);

    // Out-of-order writeback, in-order retire.
    alloc(5'd3, 1'b1);
    settle();
    chk("ord_slot0", 64'(bus.alloc_slot), 64'd0);
    tick();
    alloc(5'd4, 1'b1);
    settle();
    chk("ord_slot1", 64'(bus.alloc_slot), 64'd1);
    tick();
    alloc(5'd5, 1'b1);
    settle();
    chk("ord_slot2", 64'(bus.alloc_slot), 64'd2);
    tick();
    bus.alloc_req = 1'b0;
    wb(4'd2, 32'h0, 32'h22);
    tick();
    wb(4'd0, 32'h0, 32'h00);
    tick();
    wb(4'd1, 32'h0, 32'h11);
    settle();
    chk("ord_cv_early", 64'(bus.commit_valid), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("ord_cv_a",   64'(bus.commit_valid),     64'd1);
    chk("ord_dest_a", 64'(bus.commit_dest_reg),  64'd3);
    chk("ord_lo_a",   64'(bus.commit_result_lo), 64'h00);
    tick();
    chk("ord_cv_b",   64'(bus.commit_valid),     64'd1);
    chk("ord_dest_b", 64'(bus.commit_dest_reg),  64'd4);
    chk("ord_lo_b",   64'(bus.commit_result_lo), 64'h11);
    tick();
    chk("ord_cv_c",   64'(bus.commit_valid),     64'd1);
    chk("ord_dest_c", 64'(bus.commit_dest_reg),  64'd5);
    chk("ord_lo_c",   64'(bus.commit_result_lo), 64'h22);
    tick();
    chk("ord_cv_end", 64'(bus.commit_valid), 64'd0);
    chk("ord_tail",   64'(bus.alloc_slot),   64'd3);

    // Five in flight (slots 3..7), slots 4 and 5 done, then flush with alloc_req high.
    for (int k = 0; k < 5; k++) begin
      alloc(5'(10 + k), 1'b1);
      tick();
    end
    bus.alloc_req = 1'b0;
    wb(4'd4, 32'h0, 32'h44);
    tick();
    wb(4'd5, 32'h0, 32'h55);
    tick();
    bus.wb_valid = 1'b0;
    bus.flush    = 1'b1;
    alloc(5'd9, 1'b1);
    tick();
    bus.flush     = 1'b0;
    bus.alloc_req = 1'b0;
    settle();
    chk("fl_cv",    64'(bus.commit_valid), 64'd0);
    chk("fl_ready", 64'(bus.alloc_ready),  64'd1);
    chk("fl_slot",  64'(bus.alloc_slot),   64'd0);
    wb(4'd4, 32'h0, 32'hBAD);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("late_cv",   64'(bus.commit_valid), 64'd0);
    chk("late_slot", 64'(bus.alloc_slot),   64'd0);
    alloc(5'd1, 1'b1);
    settle();
    chk("post_fl_slot", 64'(bus.alloc_slot), 64'd0);
    tick();
    bus.alloc_req = 1'b0;
    wb(4'd0, 32'h5, 32'h55);
    tick();
    bus.wb_valid = 1'b0;
    tick();
    chk("post_fl_cv",   64'(bus.commit_valid),     64'd1);
    chk("post_fl_dest", 64'(bus.commit_dest_reg),  64'd1);
    chk("post_fl_hi",   64'(bus.commit_result_hi), 64'h5);
    chk("post_fl_lo",   64'(bus.commit_result_lo), 64'h55);

    // Forwarding lookup on slot 7 (slots 1..7 allocated).
    for (int k = 1; k <= 7; k++) begin
      alloc(5'(16 + k), k[0]);
      tick();
    end
    bus.alloc_req = 1'b0;
    wb(4'd7, 32'h0, 32'hDEAD);
    bus.rd_a_slot = 4'd7;
    bus.rd_b_slot = 4'd6;
    settle();
    chk("fwd_byp_done", 64'(bus.rd_a_done), FWD ? 64'd1 : 64'd0);
    chk("fwd_byp_data", 64'(bus.rd_a_data), FWD ? 64'hDEAD : 64'd0);
    chk("fwd_b_done",   64'(bus.rd_b_done), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("fwd_st_done", 64'(bus.rd_a_done), FWD ? 64'd1 : 64'd0);
    chk("fwd_st_data", 64'(bus.rd_a_data), FWD ? 64'hDEAD : 64'd0);

    // Grow to 10 in flight, retire slot 1 (leaving 9), then reset mid-stream.
    for (int k = 8; k <= 10; k++) begin
      alloc(5'(16 + k), 1'b1);
      tick();
    end
    bus.alloc_req = 1'b0;
    wb(4'd1, 32'h1, 32'h77);
    tick();
    bus.wb_valid = 1'b0;
    tick();
    chk("pre_rst_cv",   64'(bus.commit_valid),      64'd1);
    chk("pre_rst_dest", 64'(bus.commit_dest_reg),   64'd17);
    chk("pre_rst_dv",   64'(bus.commit_dest_valid), 64'd1);
    chk("pre_rst_lo",   64'(bus.commit_result_lo),  64'h77);
    chk("pre_rst_slot", 64'(bus.alloc_slot),        64'd11);
    reset_n = 1'b0;
    alloc(5'd2, 1'b1);
    wb(4'd2, 32'h9, 32'h99);
    tick();
    reset_n = 1'b0;
    idle_inputs();
    bus.rd_a_slot = 4'd7;
    reset_n = 1'b1;
    settle();
    chk("mrst_ready",   64'(bus.alloc_ready),       64'd1);
    chk("mrst_slot",    64'(bus.alloc_slot),        64'd0);
    chk("mrst_cv",      64'(bus.commit_valid),      64'd0);
    chk("mrst_dest",    64'(bus.commit_dest_reg),   64'd0);
    chk("mrst_dv",      64'(bus.commit_dest_valid), 64'd0);
    chk("mrst_hi",      64'(bus.commit_result_hi),  64'd0);
    chk("mrst_lo",      64'(bus.commit_result_lo),  64'd0);
    chk("mrst_rd_done", 64'(bus.rd_a_done),         64'd0);
    chk("mrst_rd_data", 64'(bus.rd_a_data),         64'd0);
    alloc(5'd7, 1'b1);
    settle();
    chk("mrst_alloc_slot", 64'(bus.alloc_slot), 64'd0);
    tick();
    bus.alloc_req = 1'b0;
    settle();
    chk("mrst_next_slot", 64'(bus.alloc_slot), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
